// File: rtl/rf_sequencer.sv
// Multicycle control stage in front of an 8x16 single-port register file.
// Sequences mv/mvi/add/sub/and through the file with datapath regs A and G.
module rf_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [2+2*ADDR_W:0]     instr,
  input  logic [DATA_W-1:0]       din,
  input  logic [DATA_W-1:0]       rf_data_out,
  output logic [ADDR_W-1:0]       rf_addr,
  output logic                    rf_rd_wr,
  output logic [DATA_W-1:0]       rf_data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    zero,
  output logic                    illegal
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, FIN
  } state_t;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;

  state_t state, state_nxt;

  logic [2+2*ADDR_W:0] ir;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   g_q;
  logic                zero_q;

  logic [2:0]          op;
  logic [ADDR_W-1:0]   rx;
  logic [ADDR_W-1:0]   ry;
  logic                is_mv;
  logic                is_mvi;
  logic                is_alu;
  logic                is_rsv;

  logic                ld_a;
  logic                ld_g_rf;
  logic                ld_alu;
  logic [DATA_W-1:0]   alu_res;

  assign op = ir[2+2*ADDR_W -: 3];
  assign rx = ir[2*ADDR_W-1 -: ADDR_W];
  assign ry = ir[ADDR_W-1:0];

  assign is_mv  = (op == OP_MV);
  assign is_mvi = (op == OP_MVI);
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) ||
                  (op == OP_AND);
  assign is_rsv = !(is_mv || is_mvi || is_alu);

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (op == OP_ADD): alu_res = a_q + rf_data_out;
      (op == OP_SUB): alu_res = a_q - rf_data_out;
      (op == OP_AND): alu_res = a_q & rf_data_out;
      default:        alu_res = '0;
    endcase
  end

  // Address and write strobe are pure state decode, so an
  // asynchronous reset drops any write that is in flight.
  always_comb begin
    state_nxt = state;
    rf_addr   = '0;
    rf_rd_wr  = 1'b0;
    ld_a      = 1'b0;
    ld_g_rf   = 1'b0;
    ld_alu    = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = T1;
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            rf_addr   = ry;
            ld_g_rf   = 1'b1;
            state_nxt = T2;
          end
          is_mvi: begin
            rf_addr   = rx;
            rf_rd_wr  = 1'b1;
            state_nxt = FIN;
          end
          is_alu: begin
            rf_addr   = rx;
            ld_a      = 1'b1;
            state_nxt = T2;
          end
          default: state_nxt = FIN;
        endcase
      end
      T2: begin
        if (is_mv) begin
          rf_addr   = rx;
          rf_rd_wr  = 1'b1;
          state_nxt = FIN;
        end else begin
          rf_addr   = ry;
          ld_alu    = 1'b1;
          state_nxt = T3;
        end
      end
      T3: begin
        rf_addr   = rx;
        rf_rd_wr  = 1'b1;
        state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ir     <= '0;
      a_q    <= '0;
      g_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && run) begin
        ir  <= instr;
        g_q <= din;
      end
      if (ld_a)    a_q <= rf_data_out;
      if (ld_g_rf) g_q <= rf_data_out;
      if (ld_alu) begin
        g_q    <= alu_res;
        zero_q <= (alu_res == '0);
      end
    end
  end

  assign rf_data_in = g_q;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign illegal    = (state == FIN) && is_rsv;
  assign zero       = zero_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Randomised bench for rf_sequencer with a behavioural register-file
// model and an instruction-level reference of results and latency.
module tb_rf_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [8:0]  instr;
  logic [15:0] din;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_addr;
  logic        rf_rd_wr;
  logic [15:0] rf_data_in;
  logic        busy;
  logic        done;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem[8];
  logic [15:0] ref_rf[8];
  bit          ref_zero;

  rf_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .instr       (instr),
    .din         (din),
    .rf_data_out (rf_data_out),
    .rf_addr     (rf_addr),
    .rf_rd_wr    (rf_rd_wr),
    .rf_data_in  (rf_data_in),
    .busy        (busy),
    .done        (done),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_data_out = mem[rf_addr];
  always @(posedge clk) if (rf_rd_wr) mem[rf_addr] <= rf_data_in;

  // Instruction-level reference: updates architectural state and
  // returns cycles from the run cycle to the done cycle.
  function automatic int model(input logic [2:0] op,
                               input logic [2:0] rx,
                               input logic [2:0] ry,
                               input logic [15:0] imm);
    logic [15:0] a, b, r;
    case (op)
      3'd0: begin ref_rf[rx] = ref_rf[ry]; return 3; end
      3'd1: begin ref_rf[rx] = imm; return 2; end
      3'd2, 3'd3, 3'd4: begin
        a = ref_rf[rx];
        b = ref_rf[ry];
        if (op == 3'd2) r = a + b;
        else if (op == 3'd3) r = a - b;
        else r = a & b;
        ref_zero = (r == 16'h0);
        ref_rf[rx] = r;
        return 4;
      end
      default: return 2;
    endcase
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic [2:0] rx,
                           input logic [2:0] ry, input logic [15:0] imm);
    int lat, n;
    bit seen, ill, regs_ok;
    lat = model(op, rx, ry, imm);
    @(negedge clk);
    run = 1'b1;
    instr = {op, rx, ry};
    din = imm;
    n = 0;
    seen = 0;
    ill = 0;
    while (n < 12 && !seen) begin
      @(posedge clk);
      #1;
      run = 1'b0;
      n++;
      if (done) begin seen = 1; ill = illegal; end
    end
    checks++;
    if (!seen || n !== lat) begin
      errors++;
      $display("FAIL latency op=%0d: got %0d (seen=%0d) want %0d",
               op, n, seen, lat);
    end
    checks++;
    if (ill !== (op > 3'd4)) begin
      errors++;
      $display("FAIL illegal op=%0d: got %0b want %0b", op, ill, op > 3'd4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse op=%0d: done=%0b busy=%0b want 0 0",
               op, done, busy);
    end
    checks++;
    if (zero !== ref_zero) begin
      errors++;
      $display("FAIL zero op=%0d: got %0b want %0b", op, zero, ref_zero);
    end
    regs_ok = 1;
    for (int i = 0; i < 8; i++) if (mem[i] !== ref_rf[i]) regs_ok = 0;
    checks++;
    if (!regs_ok) begin
      errors++;
      for (int i = 0; i < 8; i++)
        if (mem[i] !== ref_rf[i])
          $display("FAIL regfile op=%0d R%0d: got %h want %h",
                   op, i, mem[i], ref_rf[i]);
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset_n = 1'b0;
    run = 1'b0;
    instr = '0;
    din = '0;
    ref_zero = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, zero, illegal, rf_rd_wr} !== 5'b0 ||
        rf_addr !== 3'd0 || rf_data_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b done=%b zero=%b ill=%b wr=%b a=%0d d=%h",
               busy, done, zero, illegal, rf_rd_wr, rf_addr, rf_data_in);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || rf_rd_wr !== 1'b0 ||
          rf_addr !== 3'd0) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_run0: busy=%b done=%b wr=%b addr=%0d want 0",
               busy, done, rf_rd_wr, rf_addr);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < 8; i++)
      run_instr(3'd1, 3'(i), 3'd0, 16'($urandom));
  endtask

  task automatic test_mvi_mv();
    run_instr(3'd1, 3'd2, 3'd0, 16'h1234);
    run_instr(3'd0, 3'd5, 3'd2, 16'h0);
    checks++;
    if (mem[5] !== 16'h1234) begin
      errors++;
      $display("FAIL mv_r5: got %h want 1234", mem[5]);
    end
  endtask

  task automatic test_add_sub();
    run_instr(3'd1, 3'd1, 3'd0, 16'hFFFF);
    run_instr(3'd1, 3'd4, 3'd0, 16'h0001);
    run_instr(3'd2, 3'd1, 3'd4, 16'h0);
    checks++;
    if (mem[1] !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: R1=%h zero=%b want 0000 1", mem[1], zero);
    end
    run_instr(3'd3, 3'd4, 3'd1, 16'h0);
    checks++;
    if (mem[4] !== 16'h0001 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub: R4=%h zero=%b want 0001 0", mem[4], zero);
    end
  endtask

  task automatic test_same_reg();
    run_instr(3'd1, 3'd6, 3'd0, 16'h00F0);
    run_instr(3'd4, 3'd6, 3'd6, 16'h0);
    checks++;
    if (mem[6] !== 16'h00F0) begin
      errors++;
      $display("FAIL and_self: got %h want 00f0", mem[6]);
    end
    run_instr(3'd2, 3'd6, 3'd6, 16'h0);
    checks++;
    if (mem[6] !== 16'h01E0) begin
      errors++;
      $display("FAIL add_self: got %h want 01e0", mem[6]);
    end
  endtask

  task automatic test_reserved();
    logic [15:0] r;
    r = 16'($urandom);
    run_instr(3'd6, 3'd3, 3'd3, r);
    run_instr(3'd5, 3'd7, 3'd1, r);
    run_instr(3'd7, 3'd0, 3'd2, r);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_instr(3'($urandom_range(0, 7)), 3'($urandom),
                3'($urandom), 16'($urandom_range(0, 3) == 0 ?
                                  0 : $urandom));
  endtask

  task automatic test_back_to_back();
    logic [8:0]  q_i[3];
    logic [15:0] q_d[3];
    int idx, dones, cyc, lat;
    bit regs_ok;
    for (int i = 0; i < 3; i++) begin
      q_i[i] = {3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom)};
      q_d[i] = 16'($urandom);
    end
    idx = 0;
    dones = 0;
    cyc = 0;
    while (cyc < 60 && dones < 3) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (!busy && idx < 3) begin
        run = 1'b1;
        instr = q_i[idx];
        din = q_d[idx];
        lat = model(q_i[idx][8:6], q_i[idx][5:3], q_i[idx][2:0], q_d[idx]);
        idx++;
      end else if (busy) begin
        run = 1'b1;
        instr = 9'($urandom);
        din = 16'($urandom);
      end else begin
        run = 1'b0;
      end
    end
    @(negedge clk);
    run = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 3 || idx !== 3) begin
      errors++;
      $display("FAIL b2b_dones: got %0d issued %0d want 3", dones, idx);
    end
    regs_ok = 1;
    for (int i = 0; i < 8; i++) if (mem[i] !== ref_rf[i]) regs_ok = 0;
    checks++;
    if (!regs_ok || zero !== ref_zero) begin
      errors++;
      $display("FAIL b2b_state: regs_ok=%0b zero=%b want 1 %b",
               regs_ok, zero, ref_zero);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    @(negedge clk);
    run = 1'b1;
    instr = {3'd2, 3'd0, 3'd1};
    din = 16'h0;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    checks++;
    if (rf_rd_wr !== 1'b1 || rf_addr !== 3'd0) begin
      errors++;
      $display("FAIL t3_write: wr=%b addr=%0d want 1 0", rf_rd_wr, rf_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rf_rd_wr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b wr=%b want 0 0", busy, rf_rd_wr);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    ref_zero = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (mem[0] !== ref_rf[0] || seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: R0=%h want %h done_seen=%0b busy=%b",
               mem[0], ref_rf[0], seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mvi_mv();
    test_add_sub();
    test_same_reg();
    test_reserved();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
